// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the iterative integer square-root unit.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int unsigned DEF_IN_W   = 16;
  localparam int unsigned DEF_ROOT_W = DEF_IN_W / 2;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_ROOT_W);

  typedef struct packed {
    logic inc;
    logic sat;
  } round_t;

  // x >= (r+0.5)^2 exactly when the floor remainder exceeds r.
  function automatic round_t round_decide(input logic rnd,
                                          input logic rem_gt_root,
                                          input logic root_is_max);
    round_t d;
    d.inc = 1'b0;
    d.sat = 1'b0;
    if (rnd && rem_gt_root) begin
      if (root_is_max) d.sat = 1'b1;
      else             d.inc = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One radix-2 restoring square-root iteration: consumes two radicand bits,
// produces one root bit.
module isqrt_step #(
  parameter int unsigned ROOT_W = 8
) (
  input  logic [ROOT_W+1:0] i_rem,
  input  logic [ROOT_W-1:0] i_root,
  input  logic [1:0]        i_bits,
  output logic [ROOT_W+1:0] o_rem,
  output logic [ROOT_W-1:0] o_root
);

  logic [ROOT_W+1:0] w_t_lo;
  logic [ROOT_W+1:0] w_trial;
  logic              w_ge;

  // The full trial value {rem, bits} is ROOT_W+4 wide; its top two bits only
  // matter as a "definitely >= trial" flag, and the difference always fits.
  assign w_t_lo  = {i_rem[ROOT_W-1:0], i_bits};
  assign w_trial = {i_root, 2'b01};
  assign w_ge    = (|i_rem[ROOT_W+1:ROOT_W]) | (w_t_lo >= w_trial);

  assign o_rem  = w_ge ? (w_t_lo - w_trial) : w_t_lo;
  assign o_root = {i_root[ROOT_W-2:0], w_ge};

endmodule

// File: rtl/isqrt_iter.sv
// Iterative integer square root, one root bit per cycle, valid/ready on both
// sides, with remainder, optional round-to-nearest and a pass-through tag.
module isqrt_iter
  import isqrt_pkg::*;
#(
  parameter  int unsigned IN_W   = 16,
  parameter  int unsigned ID_W   = 4,
  localparam int unsigned ROOT_W = IN_W / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IN_W-1:0]   valor_i,
  input  logic              round_i,
  input  logic [ID_W-1:0]   id_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ROOT_W-1:0] root_o,
  output logic [ROOT_W:0]   rem_o,
  output logic              sat_o,
  output logic [ID_W-1:0]   id_o
);

  localparam int unsigned CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROOT_W - 1);

  state_t            r_state;
  logic [IN_W-1:0]   r_rad;
  logic [ROOT_W+1:0] r_rem;
  logic [ROOT_W-1:0] r_root;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rnd;
  logic [ID_W-1:0]   r_id;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [ROOT_W-1:0] r_root_o;
  logic [ROOT_W:0]   r_rem_o;
  logic              r_sat;
  logic [ID_W-1:0]   r_id_o;

  logic [ROOT_W+1:0] w_rem_n;
  logic [ROOT_W-1:0] w_root_n;
  logic              w_gt;
  logic              w_max;
  round_t            w_dec;

  isqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[IN_W-1:IN_W-2]),
    .o_rem  (w_rem_n),
    .o_root (w_root_n)
  );

  assign w_gt  = w_rem_n > {2'b00, w_root_n};
  assign w_max = &w_root_n;
  assign w_dec = round_decide(r_rnd, w_gt, w_max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rad       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_rnd       <= 1'b0;
      r_id        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_root_o    <= '0;
      r_rem_o     <= '0;
      r_sat       <= 1'b0;
      r_id_o      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_rad      <= valor_i;
            r_rnd      <= round_i;
            r_id       <= id_i;
            r_rem      <= '0;
            r_root     <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_rem  <= w_rem_n;
          r_root <= w_root_n;
          r_rad  <= {r_rad[IN_W-3:0], 2'b00};
          r_cnt  <= r_cnt + 1'b1;
          // Final step: the rounded result is formed straight from the step
          // outputs so DONE is entered with everything already registered.
          if (r_cnt == LAST_CNT) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_root_o    <= w_dec.inc ? (w_root_n + 1'b1) : w_root_n;
            r_rem_o     <= w_rem_n[ROOT_W:0];
            r_sat       <= w_dec.sat;
            r_id_o      <= r_id;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign root_o      = r_root_o;
  assign rem_o       = r_rem_o;
  assign sat_o       = r_sat;
  assign id_o        = r_id_o;

endmodule

// File: tb/tb_isqrt_iter.sv
// Directed and exhaustive checks of isqrt_iter at IN_W=16 and IN_W=8 against
// a brute-force square-root model via an expected-result queue.
module tb_isqrt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_round, a_out_valid, a_out_ready, a_sat;
  logic [15:0] a_valor;
  logic [3:0]  a_id, a_id_o;
  logic [7:0]  a_root;
  logic [8:0]  a_rem;

  logic        b_in_valid, b_in_ready, b_round, b_out_valid, b_out_ready, b_sat;
  logic [7:0]  b_valor;
  logic [3:0]  b_id, b_id_o;
  logic [3:0]  b_root;
  logic [4:0]  b_rem;

  isqrt_iter #(.IN_W(16), .ID_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .valor_i(a_valor), .round_i(a_round), .id_i(a_id),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .root_o(a_root), .rem_o(a_rem), .sat_o(a_sat), .id_o(a_id_o)
  );

  isqrt_iter #(.IN_W(8), .ID_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .valor_i(b_valor), .round_i(b_round), .id_i(b_id),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .root_o(b_root), .rem_o(b_rem), .sat_o(b_sat), .id_o(b_id_o)
  );

  typedef struct {
    int unsigned root;
    int unsigned rem;
    logic        sat;
    logic [3:0]  id;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input int unsigned v, input int unsigned rw,
                                 input logic rnd, input logic [3:0] id);
    exp_t e;
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    e.rem  = v - r * r;
    e.root = r;
    e.sat  = 1'b0;
    e.id   = id;
    if (rnd && e.rem > r) begin
      if (r == (1 << rw) - 1) e.sat = 1'b1;
      else                    e.root = r + 1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [15:0] v, input logic rnd, input logic [3:0] id,
                        input bit push);
    int w = 0;
    while (!a_in_ready && w < 50) begin
      @(posedge clk); @(negedge clk); w++;
    end
    chk("a_ready_before_req", a_in_ready, 1);
    a_in_valid = 1'b1; a_valor = v; a_round = rnd; a_id = id;
    if (push) qa.push_back(model(v, 8, rnd, id));
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    a_valor = 16'($urandom); a_round = 1'($urandom); a_id = 4'($urandom);
    chk("a_busy_after_accept", a_in_ready, 0);
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
  endtask

  task automatic recv_a(input string tag);
    exp_t e;
    chk({tag, "_valid"}, a_out_valid, 1);
    chk({tag, "_sb_nonempty"}, qa.size(), (qa.size() > 0) ? qa.size() : 1);
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk({tag, "_root"}, a_root, e.root);
      chk({tag, "_rem"},  a_rem,  e.rem);
      chk({tag, "_sat"},  a_sat,  e.sat);
      chk({tag, "_id"},   a_id_o, e.id);
    end
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, a_out_valid, 0);
    chk({tag, "_ready_back"}, a_in_ready, 1);
  endtask

  task automatic run_b(input logic [7:0] v, input logic rnd, input logic [3:0] id);
    exp_t e;
    int   w = 0;
    string tag;
    tag = $sformatf("b_v%0d_r%0d", v, rnd);
    while (!b_in_ready && w < 50) begin
      @(posedge clk); @(negedge clk); w++;
    end
    b_in_valid = 1'b1; b_valor = v; b_round = rnd; b_id = id;
    qb.push_back(model(v, 4, rnd, id));
    @(posedge clk); @(negedge clk);
    b_in_valid = 1'b0; b_valor = 8'($urandom); b_id = 4'($urandom);
    w = 0;
    while (!b_out_valid && w < 40) begin
      @(posedge clk); @(negedge clk); w++;
    end
    chk({tag, "_lat"}, w, 4);
    e = qb.pop_front();
    chk({tag, "_root"}, b_root, e.root);
    chk({tag, "_rem"},  b_rem,  e.rem);
    chk({tag, "_sat"},  b_sat,  e.sat);
    chk({tag, "_id"},   b_id_o, e.id);
    b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_valor = '0; a_round = 1'b0; a_id = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_valor = '0; b_round = 1'b0; b_id = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_root",      a_root, 0);
    chk("rst_rem",       a_rem, 0);
    chk("rst_sat",       a_sat, 0);
    chk("rst_id",        a_id_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_a(16'd0, 1'b0, 4'd1, 1);
    wait_a(lat);
    chk("zero_latency", lat, 8);
    recv_a("zero");

    send_a(16'hFFFF, 1'b0, 4'd2, 1);
    wait_a(lat);
    recv_a("max_trunc");
    send_a(16'hFFFF, 1'b1, 4'd4, 1);
    wait_a(lat);
    recv_a("max_round_sat");

    send_a(16'd24, 1'b1, 4'd5, 1);
    wait_a(lat);
    recv_a("v24_round");
    send_a(16'd20, 1'b1, 4'd6, 1);
    wait_a(lat);
    recv_a("v20_round");
    send_a(16'd144, 1'b1, 4'd8, 1);
    wait_a(lat);
    recv_a("v144_round");

    send_a(16'd1000, 1'b0, 4'd7, 1);
    wait_a(lat);
    a_in_valid = 1'b1; a_valor = 16'd9; a_round = 1'b0; a_id = 4'd9;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      chk("bp_valid_held", a_out_valid, 1);
      chk("bp_root_held",  a_root, 31);
      chk("bp_rem_held",   a_rem, 39);
      chk("bp_id_held",    a_id_o, 7);
      chk("bp_not_ready",  a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    recv_a("bp_release");
    seen = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (a_out_valid) seen = 1;
    end
    chk("bp_ignored_req", seen, 0);

    send_a(16'd50000, 1'b0, 4'd5, 0);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", a_in_ready, 1);
    chk("midrst_valid", a_out_valid, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (a_out_valid) seen = 1;
    end
    chk("midrst_no_result", seen, 0);
    send_a(16'd81, 1'b0, 4'd3, 1);
    wait_a(lat);
    recv_a("after_rst_81");

    for (int rm = 0; rm < 2; rm++) begin
      for (int v = 0; v < 256; v++) begin
        run_b(8'(v), 1'(rm), 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
